// File: rtl/cipher_pkg.sv
// cipher_pkg: shared constants and helpers for the Kuznyechik (GOST R 34.12-2015)
// decryption core.
//   - ROUND_KEY : fixed round keys K1..K10 (index 1..10)
//   - INV_SBOX  : inverse of the pi substitution
//   - L_COEF    : l-function coefficients, L_COEF[k] multiplies byte b_k
//   - gf_mul    : GF(2^8) multiply modulo x^8+x^7+x^6+x+1
//   - state_t   : FSM state encoding with its ST_* constants
package cipher_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LIN    = 2'd1;
  localparam logic [1:0] ST_SUBKEY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [127:0] ROUND_KEY [1:10] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'hA5, 8'h2D, 8'h32, 8'h8F, 8'h0E, 8'h30, 8'h38, 8'hC0, 8'h54, 8'hE6, 8'h9E, 8'h39, 8'h55, 8'h7E, 8'h52, 8'h91,
    8'h64, 8'h03, 8'h57, 8'h5A, 8'h1C, 8'h60, 8'h07, 8'h18, 8'h21, 8'h72, 8'hA8, 8'hD1, 8'h29, 8'hC6, 8'hA4, 8'h3F,
    8'hE0, 8'h27, 8'h8D, 8'h0C, 8'h82, 8'hEA, 8'hAE, 8'hB4, 8'h9A, 8'h63, 8'h49, 8'hE5, 8'h42, 8'hE4, 8'h15, 8'hB7,
    8'hC8, 8'h06, 8'h70, 8'h9D, 8'h41, 8'h75, 8'h19, 8'hC9, 8'hAA, 8'hFC, 8'h4D, 8'hBF, 8'h2A, 8'h73, 8'h84, 8'hD5,
    8'hC3, 8'hAF, 8'h2B, 8'h86, 8'hA7, 8'hB1, 8'hB2, 8'h5B, 8'h46, 8'hD3, 8'h9F, 8'hFD, 8'hD4, 8'h0F, 8'h9C, 8'h2F,
    8'h9B, 8'h43, 8'hEF, 8'hD9, 8'h79, 8'hB6, 8'h53, 8'h7F, 8'hC1, 8'hF0, 8'h23, 8'hE7, 8'h25, 8'h5E, 8'hB5, 8'h1E,
    8'hA2, 8'hDF, 8'hA6, 8'hFE, 8'hAC, 8'h22, 8'hF9, 8'hE2, 8'h4A, 8'hBC, 8'h35, 8'hCA, 8'hEE, 8'h78, 8'h05, 8'h6B,
    8'h51, 8'hE1, 8'h59, 8'hA3, 8'hF2, 8'h71, 8'h56, 8'h11, 8'h6A, 8'h89, 8'h94, 8'h65, 8'h8C, 8'hBB, 8'h77, 8'h3C,
    8'h7B, 8'h28, 8'hAB, 8'hD2, 8'h31, 8'hDE, 8'hC4, 8'h5F, 8'hCC, 8'hCF, 8'h76, 8'h2C, 8'hB8, 8'hD8, 8'h2E, 8'h36,
    8'hDB, 8'h69, 8'hB3, 8'h14, 8'h95, 8'hBE, 8'h62, 8'hA1, 8'h3B, 8'h16, 8'h66, 8'hE9, 8'h5C, 8'h6C, 8'h6D, 8'hAD,
    8'h37, 8'h61, 8'h4B, 8'hB9, 8'hE3, 8'hBA, 8'hF1, 8'hA0, 8'h85, 8'h83, 8'hDA, 8'h47, 8'hC5, 8'hB0, 8'h33, 8'hFA,
    8'h96, 8'h6F, 8'h6E, 8'hC2, 8'hF6, 8'h50, 8'hFF, 8'h5D, 8'hA9, 8'h8E, 8'h17, 8'h1B, 8'h97, 8'h7D, 8'hEC, 8'h58,
    8'hF7, 8'h1F, 8'hFB, 8'h7C, 8'h09, 8'h0D, 8'h7A, 8'h67, 8'h45, 8'h87, 8'hDC, 8'hE8, 8'h4F, 8'h1D, 8'h4E, 8'h04,
    8'hEB, 8'hF8, 8'hF3, 8'h3E, 8'h3D, 8'hBD, 8'h8A, 8'h88, 8'hDD, 8'hCD, 8'h0B, 8'h13, 8'h98, 8'h02, 8'h93, 8'h80,
    8'h90, 8'hD0, 8'h24, 8'h34, 8'hCB, 8'hED, 8'hF4, 8'hCE, 8'h99, 8'h10, 8'h44, 8'h40, 8'h92, 8'h3A, 8'h01, 8'h26,
    8'h12, 8'h1A, 8'h48, 8'h68, 8'hF5, 8'h81, 8'h8B, 8'hC7, 8'hD6, 8'h20, 8'h0A, 8'h08, 8'h00, 8'h4C, 8'hD7, 8'h74
  };

  // Index k is the coefficient of byte b_k (b15 = bits [127:120]).
  localparam logic [7:0] L_COEF [16] = '{
    8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
  };

  // Shift-and-add multiply; the low byte of 0x1C3 folds x^8 back into the field.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      if (sh[7]) begin
        sh = {sh[6:0], 1'b0} ^ 8'hC3;
      end else begin
        sh = {sh[6:0], 1'b0};
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/cipher_lfunc.sv
// cipher_lfunc: combinational Kuznyechik l-function.
//   i_b : 128-bit input b15..b0 (b15 = bits [127:120])
//   o_l : GF(2^8) linear combination sum(L_COEF[k] * b_k)
module cipher_lfunc
  import cipher_pkg::*;
(
  input  logic [127:0] i_b,
  output logic [7:0]   o_l
);

  // Sixteen constant multiplies folded into an XOR tree.
  always_comb begin
    o_l = 8'h00;
    for (int k = 0; k < 16; k++) begin
      o_l = o_l ^ gf_mul(i_b[8*k +: 8], L_COEF[k]);
    end
  end

endmodule

// File: rtl/cipher.sv
// cipher: iterative Kuznyechik block decryption with built-in round keys.
//   clk_i     : clock, rising edge
//   resetn_i  : asynchronous active-low reset
//   data_i    : ciphertext block, captured when request_i is accepted
//   request_i : start request, honoured only while idle
//   ack_i     : consumer acknowledge for data_o, honoured only once valid_o is high
//   data_o    : registered plaintext, holds its value after acknowledge
//   valid_o   : data_o valid
//   busy_o    : high whenever a request would not be accepted
// One R^-1 step per clock (16 per round) plus one S^-1/key cycle per round,
// nine rounds, then one cycle to register the result: 154 clocks overall.
module cipher
  import cipher_pkg::*;
(
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic [127:0] data_i,
  input  logic         request_i,
  input  logic         ack_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  output logic         busy_o
);

  state_t       r_state;
  logic [127:0] r_x;
  logic [3:0]   r_round;
  logic [3:0]   r_cnt;
  logic [127:0] r_data;
  logic         r_valid;
  logic         r_busy;

  logic [127:0] w_l_in;
  logic [7:0]   w_l_out;
  logic [127:0] w_rinv;
  logic [127:0] w_sub;
  logic [127:0] w_key;

  // R^-1 feeds l with (a14..a0, a15) and shifts the result in as the new low byte.
  assign w_l_in = {r_x[119:0], r_x[127:120]};
  assign w_rinv = {r_x[119:0], w_l_out};
  assign w_key  = ROUND_KEY[r_round];

  cipher_lfunc u_lfunc (
    .i_b (w_l_in),
    .o_l (w_l_out)
  );

  // Bytewise inverse substitution of the working block.
  always_comb begin
    w_sub = 128'h0;
    for (int k = 0; k < 16; k++) begin
      w_sub[8*k +: 8] = INV_SBOX[r_x[8*k +: 8]];
    end
  end

  // Control FSM, datapath state and registered outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
      r_x     <= 128'h0;
      r_round <= 4'd0;
      r_cnt   <= 4'd0;
      r_data  <= 128'h0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (request_i) begin
            r_x     <= data_i ^ ROUND_KEY[10];
            r_round <= 4'd9;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_LIN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LIN: begin
          r_x <= w_rinv;
          if (r_cnt == 4'd15) begin
            r_cnt   <= 4'd0;
            r_state <= ST_SUBKEY;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SUBKEY: begin
          r_x <= w_sub ^ w_key;
          if (r_round == 4'd1) begin
            r_state <= ST_DONE;
          end else begin
            r_round <= r_round - 4'd1;
            r_state <= ST_LIN;
          end
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; ack is only meaningful after that.
          if (!r_valid) begin
            r_data  <= r_x;
            r_valid <= 1'b1;
          end else if (ack_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_cipher.sv
// tb_cipher: directed self-checking bench for the cipher block.
// Expected plaintexts come from the published test vector and from an
// encryption model written here with the forward pi table; decrypting the
// model's ciphertext must reproduce the original plaintext.
module tb_cipher;

  logic         clk_i;
  logic         resetn_i;
  logic [127:0] data_i;
  logic         request_i;
  logic         ack_i;
  logic [127:0] data_o;
  logic         valid_o;
  logic         busy_o;

  int n_checks;
  int n_errors;

  localparam logic [127:0] PT_STD = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT_STD = 128'h7f679d90bebc24305a468d42b9d4edcd;

  localparam logic [127:0] KEYS [1:10] = '{
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // Coefficients in order b15..b0.
  localparam logic [7:0] LC [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  cipher dut (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .data_i    (data_i),
    .request_i (request_i),
    .ack_i     (ack_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Carry-less product followed by long division by 0x1C3.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ (15'h1C3 << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] lfun(input logic [127:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) acc = acc ^ gmul(a[127 - 8*k -: 8], LC[k]);
    return acc;
  endfunction

  // Forward Kuznyechik: X[K], S, L for keys 1..9, then X[K10].
  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] x;
    x = p;
    for (int r = 1; r <= 9; r++) begin
      x = x ^ KEYS[r];
      for (int k = 0; k < 16; k++) x[8*k +: 8] = PI[x[8*k +: 8]];
      for (int j = 0; j < 16; j++) x = {lfun(x), x[127:8]};
    end
    return x ^ KEYS[10];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for valid_o; optionally fire a
  // zero-data request 50 cycles into the operation.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input bit inject, input string tag);
    int cyc;
    data_i    = ct;
    request_i = 1'b1;
    tick();
    request_i = 1'b0;
    data_i    = 128'h0;
    check({tag, "_busy"}, 128'(busy_o), 128'h1);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 400) begin
      if (inject && cyc == 50) begin
        request_i = 1'b1;
      end else begin
        request_i = 1'b0;
      end
      tick();
      cyc++;
    end
    request_i = 1'b0;
    check({tag, "_latency"}, 128'(cyc), 128'd154);
    check({tag, "_data"}, data_o, pt);
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    logic [127:0] pts [11];
    n_checks  = 0;
    n_errors  = 0;
    resetn_i  = 1'b0;
    data_i    = 128'h0;
    request_i = 1'b0;
    ack_i     = 1'b0;

    tick();
    tick();
    check("rst_data", data_o, 128'h0);
    check("rst_valid", 128'(valid_o), 128'h0);
    check("rst_busy", 128'(busy_o), 128'h0);
    resetn_i = 1'b1;
    tick();

    // Acknowledge while idle changes nothing.
    ack_pulse();
    tick();
    check("idle_ack_valid", 128'(valid_o), 128'h0);
    check("idle_ack_busy", 128'(busy_o), 128'h0);

    check("model_std", enc(PT_STD), CT_STD);

    // Standard vector with an ignored request mid-flight.
    run_block(CT_STD, PT_STD, 1'b1, "std");

    // Output holds while the consumer withholds ack.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", 128'(valid_o), 128'h1);
      check("hold_busy", 128'(busy_o), 128'h1);
      check("hold_data", data_o, PT_STD);
    end
    ack_pulse();
    check("ack_valid", 128'(valid_o), 128'h0);
    check("ack_busy", 128'(busy_o), 128'h0);
    check("ack_data_kept", data_o, PT_STD);

    // Eleven back-to-back blocks against the encryption model.
    for (int i = 0; i < 11; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 11; i++) begin
      run_block(enc(pts[i]), pts[i], 1'b0, "b2b");
      if (i == 0) begin
        // ack together with request: only the return to idle happens.
        data_i    = enc(pts[1]);
        request_i = 1'b1;
        ack_pulse();
        request_i = 1'b0;
        check("ackreq_busy", 128'(busy_o), 128'h0);
        check("ackreq_valid", 128'(valid_o), 128'h0);
      end else begin
        ack_pulse();
      end
    end

    // Reset 50 cycles into an operation aborts it.
    data_i    = CT_STD;
    request_i = 1'b1;
    tick();
    request_i = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    resetn_i = 1'b0;
    #1;
    check("abort_data", data_o, 128'h0);
    check("abort_valid", 128'(valid_o), 128'h0);
    check("abort_busy", 128'(busy_o), 128'h0);
    #2;
    resetn_i = 1'b1;
    for (int i = 0; i < 160; i++) tick();
    check("abort_no_valid", 128'(valid_o), 128'h0);
    run_block(CT_STD, PT_STD, 1'b0, "post_rst");
    ack_pulse();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
